// File: rtl/move_target_planner.sv
// Turns linear move commands into absolute, soft-limited targets (0.01 mm) for the kinematics stage.
// Optional macro SOFT_LIMIT_CLAMP_EN enables soft-limit saturation in the CLAMP state.
module move_target_planner #(
   parameter int X_MIN  = 0,
   parameter int X_MAX  = 60000,
   parameter int Y_MIN  = -30000,
   parameter int Y_MAX  = 30000,
   parameter int HOME_X = 0,
   parameter int HOME_Y = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_strobe,
   input  logic [4:0]  mode_reg,
   input  logic [13:0] x_in,
   input  logic [13:0] y_in,
   input  logic        move_ack,
   output logic        planner_ready,
   output logic        move_valid,
   output logic [21:0] target_x,
   output logic [21:0] target_y,
   output logic        pen_up,
   output logic        clamped,
   output logic        overrun
);

   localparam int unsigned PW = 22;
   localparam int unsigned IW = 14;
   localparam logic [7:0]  SCALE = 8'd254;
   localparam logic signed [PW-1:0] XMIN_C  = PW'(X_MIN);
   localparam logic signed [PW-1:0] XMAX_C  = PW'(X_MAX);
   localparam logic signed [PW-1:0] YMIN_C  = PW'(Y_MIN);
   localparam logic signed [PW-1:0] YMAX_C  = PW'(Y_MAX);
   localparam logic signed [PW-1:0] HOMEX_C = PW'(HOME_X);
   localparam logic signed [PW-1:0] HOMEY_C = PW'(HOME_Y);
`ifdef SOFT_LIMIT_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_SUM, S_CLAMP, S_ISSUE} state_t;

   state_t                 state_q, state_d;
   logic                   strobe_q;
   logic                   pend_v_q, pend_v_d;
   logic [IW-1:0]          pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic                   pend_abs_q, pend_abs_d, pend_inch_q, pend_inch_d;
   logic signed [PW-1:0]   wx_q, wx_d, wy_q, wy_d;
   logic                   w_abs_q, w_abs_d;
   logic signed [PW-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [2:0]             bit_q, bit_d;
   logic signed [PW-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic signed [PW-1:0]   tx_q, tx_d, ty_q, ty_d;
   logic signed [PW-1:0]   target_x_q, target_x_d, target_y_q, target_y_d;
   logic                   move_valid_q, move_valid_d;
   logic                   clamped_q, clamped_d;
   logic                   overrun_q, overrun_d;
   logic                   pen_up_q, pen_up_d;
   logic                   ready_q, ready_d;
   logic                   move_evt_c;
   logic                   ld_inch_c;
   logic                   start_c;

   function automatic logic signed [PW-1:0] sext(input logic [IW-1:0] v);
      return {{(PW-IW){v[IW-1]}}, v};
   endfunction

   function automatic logic signed [PW-1:0] sat(input logic signed [PW-1:0] v,
                                                input logic signed [PW-1:0] lo,
                                                input logic signed [PW-1:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   assign move_evt_c = cmd_strobe & ~strobe_q & mode_reg[0];

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      pend_v_d     = pend_v_q;
      pend_x_d     = pend_x_q;
      pend_y_d     = pend_y_q;
      pend_abs_d   = pend_abs_q;
      pend_inch_d  = pend_inch_q;
      wx_d         = wx_q;
      wy_d         = wy_q;
      w_abs_d      = w_abs_q;
      acc_x_d      = acc_x_q;
      acc_y_d      = acc_y_q;
      bit_d        = bit_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      tx_d         = tx_q;
      ty_d         = ty_q;
      target_x_d   = target_x_q;
      target_y_d   = target_y_q;
      move_valid_d = move_valid_q;
      clamped_d    = clamped_q;
      overrun_d    = overrun_q;
      pen_up_d     = mode_reg[3];
      ld_inch_c    = 1'b0;
      start_c      = 1'b0;

      // Busy: fresh moves go to the single pending slot, or are dropped
      if (state_q != S_IDLE && move_evt_c) begin
         if (pend_v_q) begin
            overrun_d = 1'b1;
         end else begin
            pend_v_d    = 1'b1;
            pend_x_d    = x_in;
            pend_y_d    = y_in;
            pend_abs_d  = mode_reg[2];
            pend_inch_d = mode_reg[1];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (pend_v_q) begin
               wx_d      = sext(pend_x_q);
               wy_d      = sext(pend_y_q);
               w_abs_d   = pend_abs_q;
               ld_inch_c = pend_inch_q;
               start_c   = 1'b1;
               pend_v_d  = 1'b0;
               if (move_evt_c) begin
                  pend_v_d    = 1'b1;
                  pend_x_d    = x_in;
                  pend_y_d    = y_in;
                  pend_abs_d  = mode_reg[2];
                  pend_inch_d = mode_reg[1];
               end
            end else if (move_evt_c) begin
               wx_d      = sext(x_in);
               wy_d      = sext(y_in);
               w_abs_d   = mode_reg[2];
               ld_inch_c = mode_reg[1];
               start_c   = 1'b1;
            end
            if (start_c) begin
               acc_x_d = '0;
               acc_y_d = '0;
               bit_d   = '0;
               state_d = ld_inch_c ? S_MUL : S_SUM;
            end
         end
         S_MUL: begin
            acc_x_d = acc_x_q + (SCALE[bit_q] ? (wx_q <<< bit_q) : '0);
            acc_y_d = acc_y_q + (SCALE[bit_q] ? (wy_q <<< bit_q) : '0);
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
               wx_d    = acc_x_d;
               wy_d    = acc_y_d;
               state_d = S_SUM;
            end
         end
         S_SUM: begin
            tx_d    = w_abs_q ? wx_q : cur_x_q + wx_q;
            ty_d    = w_abs_q ? wy_q : cur_y_q + wy_q;
            state_d = S_CLAMP;
         end
         S_CLAMP: begin
            target_x_d   = CLAMP_EN ? sat(tx_q, XMIN_C, XMAX_C) : tx_q;
            target_y_d   = CLAMP_EN ? sat(ty_q, YMIN_C, YMAX_C) : ty_q;
            clamped_d    = CLAMP_EN && ((target_x_d != tx_q) || (target_y_d != ty_q));
            move_valid_d = 1'b1;
            state_d      = S_ISSUE;
         end
         S_ISSUE: begin
            if (move_valid_q && move_ack) begin
               cur_x_d      = target_x_q;
               cur_y_d      = target_y_q;
               move_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE) && !pend_v_d;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         strobe_q     <= 1'b0;
         pend_v_q     <= 1'b0;
         pend_x_q     <= '0;
         pend_y_q     <= '0;
         pend_abs_q   <= 1'b0;
         pend_inch_q  <= 1'b0;
         wx_q         <= '0;
         wy_q         <= '0;
         w_abs_q      <= 1'b0;
         acc_x_q      <= '0;
         acc_y_q      <= '0;
         bit_q        <= '0;
         cur_x_q      <= HOMEX_C;
         cur_y_q      <= HOMEY_C;
         tx_q         <= '0;
         ty_q         <= '0;
         target_x_q   <= '0;
         target_y_q   <= '0;
         move_valid_q <= 1'b0;
         clamped_q    <= 1'b0;
         overrun_q    <= 1'b0;
         pen_up_q     <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         strobe_q     <= cmd_strobe;
         pend_v_q     <= pend_v_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         pend_abs_q   <= pend_abs_d;
         pend_inch_q  <= pend_inch_d;
         wx_q         <= wx_d;
         wy_q         <= wy_d;
         w_abs_q      <= w_abs_d;
         acc_x_q      <= acc_x_d;
         acc_y_q      <= acc_y_d;
         bit_q        <= bit_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         tx_q         <= tx_d;
         ty_q         <= ty_d;
         target_x_q   <= target_x_d;
         target_y_q   <= target_y_d;
         move_valid_q <= move_valid_d;
         clamped_q    <= clamped_d;
         overrun_q    <= overrun_d;
         pen_up_q     <= pen_up_d;
         ready_q      <= ready_d;
      end
   end

   assign planner_ready = ready_q;
   assign move_valid    = move_valid_q;
   assign target_x      = target_x_q;
   assign target_y      = target_y_q;
   assign pen_up        = pen_up_q;
   assign clamped       = clamped_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_move_target_planner.sv
// Directed self-checking bench for move_target_planner (X_MAX overridden to 5000).
module tb_move_target_planner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_strobe;
   logic [4:0]  mode_reg;
   logic [13:0] x_in, y_in;
   logic        move_ack;
   logic        planner_ready, move_valid, pen_up, clamped, overrun;
   logic [21:0] target_x, target_y;

   int tests = 0;
   int fails = 0;

`ifdef SOFT_LIMIT_CLAMP_EN
   localparam int  EXP_CLAMP_X = 5000;
   localparam logic EXP_CLAMP_F = 1'b1;
`else
   localparam int  EXP_CLAMP_X = 8000;
   localparam logic EXP_CLAMP_F = 1'b0;
`endif

   always #5 clk = ~clk;

   move_target_planner #(.X_MAX(5000)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_strobe(cmd_strobe), .mode_reg(mode_reg),
      .x_in(x_in), .y_in(y_in), .move_ack(move_ack),
      .planner_ready(planner_ready), .move_valid(move_valid),
      .target_x(target_x), .target_y(target_y), .pen_up(pen_up),
      .clamped(clamped), .overrun(overrun)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raise the strobe for one cycle; returns just after the capturing edge
   task automatic strobe_move(input logic [4:0] m, input int x, input int y);
      mode_reg   = m;
      x_in       = 14'(x);
      y_in       = 14'(y);
      cmd_strobe = 1'b1;
      tick(1);
      cmd_strobe = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_strobe = 1'b0; mode_reg = '0; x_in = '0; y_in = '0; move_ack = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      tests++; if (planner_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", planner_ready); end
      tests++; if (move_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", move_valid); end
      tests++; if (target_x !== 22'd0 || target_y !== 22'd0) begin fails++; $display("FAIL reset_target got %0d/%0d exp 0/0", $signed(target_x), $signed(target_y)); end
      tests++; if (overrun !== 1'b0 || clamped !== 1'b0 || pen_up !== 1'b0) begin fails++; $display("FAIL reset_flags got ovr=%b clp=%b pen=%b exp 0", overrun, clamped, pen_up); end
   endtask

   task automatic test_abs_mm();
      move_ack = 1'b1;
      strobe_move(5'b00101, 1000, -500);
      tick(1);
      tests++; if (move_valid !== 1'b0) begin fails++; $display("FAIL mm_early_valid got %b exp 0", move_valid); end
      tests++; if (planner_ready !== 1'b0) begin fails++; $display("FAIL mm_busy_ready got %b exp 0", planner_ready); end
      tick(1);
      tests++; if (move_valid !== 1'b1) begin fails++; $display("FAIL mm_valid got %b exp 1", move_valid); end
      tests++; if (target_x !== 22'(1000) || target_y !== 22'(-500)) begin fails++; $display("FAIL mm_target got %0d/%0d exp 1000/-500", $signed(target_x), $signed(target_y)); end
      tests++; if (clamped !== 1'b0) begin fails++; $display("FAIL mm_clamped got %b exp 0", clamped); end
      tick(1);
      tests++; if (planner_ready !== 1'b1 || move_valid !== 1'b0) begin fails++; $display("FAIL mm_done got rdy=%b vld=%b exp 1/0", planner_ready, move_valid); end
   endtask

   task automatic test_abs_inch();
      move_ack = 1'b1;
      strobe_move(5'b00111, 10, -3);
      tick(9);
      tests++; if (move_valid !== 1'b0) begin fails++; $display("FAIL inch_early_valid got %b exp 0", move_valid); end
      tick(1);
      tests++; if (move_valid !== 1'b1) begin fails++; $display("FAIL inch_valid got %b exp 1", move_valid); end
      tests++; if (target_x !== 22'(2540) || target_y !== 22'(-762)) begin fails++; $display("FAIL inch_target got %0d/%0d exp 2540/-762", $signed(target_x), $signed(target_y)); end
      tick(2);
   endtask

   task automatic test_relative();
      move_ack = 1'b1;
      strobe_move(5'b00101, 1000, 0);
      tick(4);
      strobe_move(5'b00001, 250, 250);
      tick(2);
      tests++; if (move_valid !== 1'b1 || target_x !== 22'(1250) || target_y !== 22'(250)) begin fails++; $display("FAIL rel_target got vld=%b %0d/%0d exp 1 1250/250", move_valid, $signed(target_x), $signed(target_y)); end
      tick(2);
   endtask

   task automatic test_clamp();
      move_ack = 1'b1;
      strobe_move(5'b00101, 8000, -100);
      tick(2);
      tests++; if (target_x !== 22'(EXP_CLAMP_X) || target_y !== 22'(-100)) begin fails++; $display("FAIL clamp_target got %0d/%0d exp %0d/-100", $signed(target_x), $signed(target_y), EXP_CLAMP_X); end
      tests++; if (clamped !== EXP_CLAMP_F) begin fails++; $display("FAIL clamp_flag got %b exp %b", clamped, EXP_CLAMP_F); end
      tick(2);
   endtask

   task automatic test_non_move();
      move_ack = 1'b1;
      strobe_move(5'b01000, 77, 77);
      tests++; if (pen_up !== 1'b1) begin fails++; $display("FAIL pen_up_set got %b exp 1", pen_up); end
      tick(4);
      tests++; if (move_valid !== 1'b0 || planner_ready !== 1'b1) begin fails++; $display("FAIL non_move_ignored got vld=%b rdy=%b exp 0/1", move_valid, planner_ready); end
      mode_reg = 5'b00000;
      tick(1);
      tests++; if (pen_up !== 1'b0) begin fails++; $display("FAIL pen_up_clr got %b exp 0", pen_up); end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      move_ack = 1'b0;
      strobe_move(5'b00101, 100, 100);
      tick(2);
      tests++; if (move_valid !== 1'b1) begin fails++; $display("FAIL b2b_first_valid got %b exp 1", move_valid); end
      strobe_move(5'b00101, 200, -200);
      tick(1);
      tests++; if (overrun !== 1'b0 || planner_ready !== 1'b0) begin fails++; $display("FAIL b2b_queued got ovr=%b rdy=%b exp 0/0", overrun, planner_ready); end
      strobe_move(5'b00101, 300, 300);
      tick(1);
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun got %b exp 1", overrun); end
      for (int i = 0; i < 16; i++) begin
         if (move_valid !== 1'b1 || target_x !== 22'(100) || target_y !== 22'(100)) bad++;
         tick(1);
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL b2b_hold got %0d unstable cycles exp 0", bad); end
      move_ack = 1'b1;
      tick(1);
      tests++; if (move_valid !== 1'b0) begin fails++; $display("FAIL b2b_ack got %b exp 0", move_valid); end
      tick(3);
      tests++; if (move_valid !== 1'b1 || target_x !== 22'(200) || target_y !== 22'(-200)) begin fails++; $display("FAIL b2b_pending got vld=%b %0d/%0d exp 1 200/-200", move_valid, $signed(target_x), $signed(target_y)); end
      tick(1);
      tests++; if (move_valid !== 1'b0 || planner_ready !== 1'b1 || overrun !== 1'b1) begin fails++; $display("FAIL b2b_drained got vld=%b rdy=%b ovr=%b exp 0/1/1", move_valid, planner_ready, overrun); end
   endtask

   task automatic test_reset_mid();
      move_ack = 1'b1;
      strobe_move(5'b00111, 100, 100);
      tick(3);
      rst_n = 1'b0;
      #1;
      tests++; if (move_valid !== 1'b0 || planner_ready !== 1'b1 || overrun !== 1'b0 || clamped !== 1'b0) begin fails++; $display("FAIL midrst_flags got vld=%b rdy=%b ovr=%b clp=%b exp 0/1/0/0", move_valid, planner_ready, overrun, clamped); end
      tests++; if (target_x !== 22'd0 || target_y !== 22'd0) begin fails++; $display("FAIL midrst_target got %0d/%0d exp 0/0", $signed(target_x), $signed(target_y)); end
      tick(2);
      rst_n = 1'b1;
      tick(1);
      strobe_move(5'b00001, 10, 20);
      tick(2);
      tests++; if (move_valid !== 1'b1 || target_x !== 22'(10) || target_y !== 22'(20)) begin fails++; $display("FAIL midrst_home got vld=%b %0d/%0d exp 1 10/20", move_valid, $signed(target_x), $signed(target_y)); end
      tick(2);
   endtask

   initial begin
      test_reset();
      test_abs_mm();
      test_abs_inch();
      test_relative();
      test_clamp();
      test_non_move();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
